pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_stage_reg_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 90 +++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and field offsets for the pipeline boundary registers.
// The ID/EX offsets locate each control and data field inside the packed vectors.
package pipe_pkg;

  // Per-boundary widths
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 7;
  localparam int IDEX_DATA_W  = 143;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // ID/EX control bit indices
  localparam int IDEX_REG_WRITE_EN = 0;
  localparam int IDEX_MEM2REG_SEL  = 1;
  localparam int IDEX_MEM_WRITE_EN = 2;
  localparam int IDEX_BRANCH       = 3;
  localparam int IDEX_ALU_CTRL     = 4;
  localparam int IDEX_ALU_SRC      = 5;
  localparam int IDEX_REG_DST_SEL  = 6;

  // ID/EX data field LSB offsets
  localparam int IDEX_REG_DATA1_LSB    = 0;
  localparam int IDEX_REG_DATA2_LSB    = 32;
  localparam int IDEX_IMM_SIGN_EXT_LSB = 64;
  localparam int IDEX_IMM_ZERO_EXT_LSB = 96;
  localparam int IDEX_RT_ADDR_LSB      = 128;
  localparam int IDEX_RD_ADDR_LSB      = 133;
  localparam int IDEX_SHAMT_LSB        = 138;

  // Valid/ready handshake: a transfer happens on a rising edge where valid
  // and ready are both high; valid never depends on ready, and an offered
  // entry stays stable until it transfers (or is squashed by a flush).
  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot of the stage: valid flag, control field and data field.
// load wins over clear; clear drops valid and, with ZERO_CTRL, zeroes the control field.
module pipe_slot #(
  parameter int CTRL_W    = 7,
  parameter int DATA_W    = 143,
  parameter bit ZERO_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end else if (clear) begin
      valid <= 1'b0;
      // Data is kept on purpose; only control can cause side effects downstream.
      if (ZERO_CTRL) ctrl <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main slot drives the outputs, a skid slot
// absorbs one entry under backpressure so In_Ready is purely registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = IDEX_CTRL_W,
  parameter int DATA_W    = IDEX_DATA_W,
  parameter bit ZERO_CTRL = 1'b1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [OCC_W-1:0]  Occupancy
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
  logic [DATA_W-1:0] m_data, s_data, m_data_d;
  logic              m_load, m_clear, s_load, s_clear;
  logic              accept, pop;

  assign accept = In_Valid & In_Ready;
  assign pop    = m_valid & Out_Ready;

  always_comb begin
    m_load   = 1'b0;
    m_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = !s_valid;
    m_ctrl_d = In_Ctrl;
    m_data_d = In_Data;
    if (FLUSH) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (pop || !m_valid) begin
      // Skid entry is older than anything upstream, so it moves first.
      if (s_valid) begin
        m_load   = 1'b1;
        m_ctrl_d = s_ctrl;
        m_data_d = s_data;
        s_clear  = 1'b1;
      end else if (accept) begin
        m_load = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (accept) begin
      s_load = 1'b1;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_CTRL(ZERO_CTRL)) u_main (
    .clk    (CLOCK),
    .rst    (RESET),
    .load   (m_load),
    .clear  (m_clear),
    .ctrl_d (m_ctrl_d),
    .data_d (m_data_d),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_CTRL(ZERO_CTRL)) u_skid (
    .clk    (CLOCK),
    .rst    (RESET),
    .load   (s_load),
    .clear  (s_clear),
    .ctrl_d (In_Ctrl),
    .data_d (In_Data),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );

  assign Out_Valid = m_valid;
  assign Out_Ctrl  = m_ctrl;
  assign Out_Data  = m_data;
  assign In_Ready  = !s_valid;
  assign Occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances share stimulus, one with
// bubble control zeroing and one that holds the last control value.
module tb_pipe_stage_reg;
  localparam int CW = 7;
  localparam int DW = 143;

  // Clock / reset
  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          FLUSH = 1'b0;
  logic          In_Valid = 1'b0;
  logic [CW-1:0] In_Ctrl = '0;
  logic [DW-1:0] In_Data = '0;
  logic          Out_Ready = 1'b0;

  logic          in_ready, out_valid, in_ready_z, out_valid_z;
  logic [CW-1:0] out_ctrl, out_ctrl_z;
  logic [DW-1:0] out_data, out_data_z;
  logic [1:0]    occ, occ_z;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .ZERO_CTRL(1'b1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
    .In_Valid(In_Valid), .In_Ready(in_ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(out_valid), .Out_Ready(Out_Ready), .Out_Ctrl(out_ctrl),
    .Out_Data(out_data), .Occupancy(occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .ZERO_CTRL(1'b0)) dut_hold (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
    .In_Valid(In_Valid), .In_Ready(in_ready_z), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(out_valid_z), .Out_Ready(Out_Ready), .Out_Ctrl(out_ctrl_z),
    .Out_Data(out_data_z), .Occupancy(occ_z)
  );

  // Scoreboard: single comparison point
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {3'b101, {20{c}}};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    In_Valid = v;
    In_Ctrl  = c;
    In_Data  = mk_data(c);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [CW-1:0] c,
                           input logic rdy, input logic [1:0] o);
    check({tag, "_valid"}, DW'(out_valid), DW'(v));
    check({tag, "_ctrl"},  DW'(out_ctrl),  DW'(c));
    check({tag, "_ready"}, DW'(in_ready),  DW'(rdy));
    check({tag, "_occ"},   DW'(occ),       DW'(o));
  endtask

  initial begin
    // Reset state
    #12;
    check_out("rst", 1'b0, 7'h00, 1'b1, 2'd0);
    check("rst_data", out_data, '0);
    RESET = 1'b0;

    // Streaming at full rate
    Out_Ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CW'(i));
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, CW'(i), 1'b1, 2'd1);
      check($sformatf("stream%0d_data", i), out_data, mk_data(CW'(i)));
    end
    drive(1'b0, 7'h00);
    tick();
    check_out("stream_drain", 1'b0, 7'h00, 1'b1, 2'd0);
    tick();
    check_out("empty_idle", 1'b0, 7'h00, 1'b1, 2'd0);

    // Backpressure: A, B fill, C waits upstream
    Out_Ready = 1'b0;
    drive(1'b1, 7'h11);
    tick();
    check_out("bp_a", 1'b1, 7'h11, 1'b1, 2'd1);
    drive(1'b1, 7'h22);
    tick();
    check_out("bp_b", 1'b1, 7'h11, 1'b0, 2'd2);
    drive(1'b1, 7'h33);
    tick();
    check_out("bp_c_held", 1'b1, 7'h11, 1'b0, 2'd2);
    Out_Ready = 1'b1;
    tick();
    check_out("bp_pop_a", 1'b1, 7'h22, 1'b1, 2'd1);
    check("bp_pop_a_data", out_data, mk_data(7'h22));
    tick();
    check_out("bp_pop_b", 1'b1, 7'h33, 1'b1, 2'd1);
    drive(1'b0, 7'h00);
    tick();
    check_out("bp_pop_c", 1'b0, 7'h00, 1'b1, 2'd0);

    // Flush while full with a new entry offered
    Out_Ready = 1'b0;
    drive(1'b1, 7'h44);
    tick();
    drive(1'b1, 7'h55);
    tick();
    check_out("fl_full", 1'b1, 7'h44, 1'b0, 2'd2);
    FLUSH = 1'b1;
    Out_Ready = 1'b1;
    drive(1'b1, 7'h7F);
    tick();
    check_out("fl_edge", 1'b0, 7'h00, 1'b1, 2'd0);
    check("fl_data_kept", out_data, mk_data(7'h44));
    FLUSH = 1'b0;
    drive(1'b0, 7'h00);
    tick();
    check_out("fl_after", 1'b0, 7'h00, 1'b1, 2'd0);

    // Bubble control zeroing vs holding
    drive(1'b1, 7'h7F);
    tick();
    check_out("bub_load", 1'b1, 7'h7F, 1'b1, 2'd1);
    check("bub_load_hold_ctrl", DW'(out_ctrl_z), DW'(7'h7F));
    drive(1'b0, 7'h00);
    tick();
    check_out("bub_zero", 1'b0, 7'h00, 1'b1, 2'd0);
    check("bub_zero_data", out_data, mk_data(7'h7F));
    check("bub_hold_valid", DW'(out_valid_z), DW'(1'b0));
    check("bub_hold_ctrl", DW'(out_ctrl_z), DW'(7'h7F));
    check("bub_hold_data", out_data_z, mk_data(7'h7F));

    // Asynchronous reset mid-stream while full
    Out_Ready = 1'b0;
    drive(1'b1, 7'h66);
    tick();
    drive(1'b1, 7'h77);
    tick();
    check_out("ar_full", 1'b1, 7'h66, 1'b0, 2'd2);
    drive(1'b0, 7'h00);
    #3;
    RESET = 1'b1;
    #1;
    check_out("ar_now", 1'b0, 7'h00, 1'b1, 2'd0);
    check("ar_now_data", out_data, '0);
    check("ar_now_hold_ctrl", DW'(out_ctrl_z), '0);
    #2;
    RESET = 1'b0;
    Out_Ready = 1'b1;
    drive(1'b1, 7'h0A);
    tick();
    check_out("ar_resume", 1'b1, 7'h0A, 1'b1, 2'd1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog bound
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
